// File: rtl/arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit
// Description : Registered 16-bit unsigned add/sub/mul/div unit, 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_1,
  input  logic [15:0] data_2,
  input  logic [1:0]  op_sel,
  output logic [15:0] data_out
);

  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_mul = 2'b10;
  localparam logic [1:0] c_op_div = 2'b11;

  logic [15:0] w_quotient;
  logic [15:0] w_result;

  // Guard the divider so a zero divisor never reaches the '/' operator.
  always_comb begin
    w_quotient = 16'hFFFF;
    if (data_2 != 16'h0000) begin
      w_quotient = data_1 / data_2;
    end
  end

  always_comb begin
    w_result = data_1 + data_2;
    case (op_sel)
      c_op_add: w_result = data_1 + data_2;
      c_op_sub: w_result = data_1 - data_2;
      c_op_mul: w_result = data_1 * data_2;
      c_op_div: w_result = w_quotient;
      default:  w_result = data_1 + data_2;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= 16'h0000;
    end else begin
      data_out <= w_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit
// Description : Directed self-checking bench for arith_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit;

  logic        clk;
  logic        reset;
  logic [15:0] data_1;
  logic [15:0] data_2;
  logic [1:0]  op_sel;
  logic [15:0] data_out;

  int n_checks;
  int n_fails;

  arith_unit u_dut (
    .clk      (clk),
    .reset    (reset),
    .data_1   (data_1),
    .data_2   (data_2),
    .op_sel   (op_sel),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] observed,
                          input logic [15:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, observed, expected);
    end
  endtask

  // Present operands on the falling edge, then sample just after the next rising edge.
  task automatic apply_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [15:0] expected);
    @(negedge clk);
    data_1 = a;
    data_2 = b;
    op_sel = op;
    @(posedge clk);
    #1;
    check_eq(tag, data_out, expected);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    data_1   = 16'd3;
    data_2   = 16'd4;
    op_sel   = 2'b00;

    // Test 1: reset holds output low across an edge, then 3+4 appears.
    #1 reset = 1'b1;
    #1 check_eq("reset_async", data_out, 16'h0000);
    @(posedge clk);
    #1 check_eq("reset_edge", data_out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset_release_hold", data_out, 16'h0000);
    @(posedge clk);
    #1 check_eq("add_3_4", data_out, 16'd7);

    // Test 2: subtract, including borrow wrap.
    apply_op("sub_9_2", 16'd9, 16'd2, 2'b01, 16'd7);
    apply_op("sub_2_5", 16'd2, 16'd5, 2'b01, 16'hFFFD);

    // Test 3: multiply, including truncation of the upper product bits.
    apply_op("mul_6_7", 16'd6, 16'd7, 2'b10, 16'd42);
    apply_op("mul_trunc", 16'h0100, 16'h0100, 2'b10, 16'h0000);
    apply_op("mul_ff_ff", 16'h00FF, 16'h00FF, 2'b10, 16'hFE01);

    // Test 4: divide, including divide by zero.
    apply_op("div_9_2", 16'd9, 16'd2, 2'b11, 16'd4);
    apply_op("div_7_0", 16'd7, 16'd0, 2'b11, 16'hFFFF);
    apply_op("div_0_3", 16'd0, 16'd3, 2'b11, 16'd0);
    apply_op("div_max_1", 16'hFFFF, 16'd1, 2'b11, 16'hFFFF);

    // Additional add wrap.
    apply_op("add_wrap", 16'hFFFF, 16'd2, 2'b00, 16'h0001);

    // Test 5: back-to-back ops on consecutive edges.
    apply_op("b2b_add", 16'd8, 16'd3, 2'b00, 16'd11);
    apply_op("b2b_sub", 16'd8, 16'd3, 2'b01, 16'd5);
    apply_op("b2b_mul", 16'd8, 16'd3, 2'b10, 16'd24);
    apply_op("b2b_div", 16'd8, 16'd3, 2'b11, 16'd2);

    // Held result: no input change, output stays stable across an edge.
    @(posedge clk);
    #1 check_eq("hold_div", data_out, 16'd2);

    // Test 6: asynchronous reset mid-cycle while data_out = 42.
    apply_op("mul_pre_reset", 16'd6, 16'd7, 2'b10, 16'd42);
    #2 reset = 1'b1;
    #1 check_eq("midcycle_reset", data_out, 16'h0000);
    @(posedge clk);
    #1 check_eq("reset_hold_1", data_out, 16'h0000);
    @(posedge clk);
    #1 check_eq("reset_hold_2", data_out, 16'h0000);
    @(negedge clk);
    reset  = 1'b0;
    data_1 = 16'd8;
    data_2 = 16'd3;
    op_sel = 2'b01;
    @(posedge clk);
    #1 check_eq("post_reset_first", data_out, 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
